// File: rtl/spdif_aes3_receiver_pkg.sv
// Shared types and constants for the S/PDIF/AES3 biphase-mark receiver.
// Pulse classes, FSM states, preamble kinds and the preamble pulse signatures.
package spdif_aes3_receiver_pkg;

   typedef enum logic [1:0] {T1, T2, T3, BAD} pulse_t;
   typedef enum logic [1:0] {HUNT, PRE, DATA} rx_state_t;
   typedef enum logic [1:0] {PRE_X, PRE_Y, PRE_Z} pre_kind_t;
   typedef enum logic {LEFT, RIGHT} subframe_t;

   // Three pulses that follow the leading T3 of each preamble, first pulse in the MSBs.
   localparam logic [5:0] PAT_X = {T3, T1, T1};
   localparam logic [5:0] PAT_Y = {T2, T1, T2};
   localparam logic [5:0] PAT_Z = {T1, T1, T3};

   localparam logic [4:0] SLOT_FIRST = 5'd4;
   localparam logic [4:0] SLOT_LAST  = 5'd31;

endpackage

// File: rtl/spdif_aes3_pulse_meter.sv
// Synchronises the line, finds edges and classifies the width between them.
// Latency: line edge to pulse_vld is 3 clk. No backpressure: one result per edge or saturation.
module spdif_aes3_pulse_meter
   import spdif_aes3_receiver_pkg::*;
#(
   parameter int OVS = 4
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   rx_i,
   output logic   pulse_vld,
   output pulse_t pulse_dat
);

   localparam int CW = $clog2(4 * OVS + 2);
   localparam logic [CW-1:0] SAT    = CW'(4 * OVS);
   localparam logic [CW-1:0] SAT_M1 = CW'(4 * OVS - 1);
   // Thresholds are compared against 2*w so odd OVS/2 boundaries stay exact.
   localparam logic [CW:0] TH_1 = (CW + 1)'(OVS);
   localparam logic [CW:0] TH_3 = (CW + 1)'(3 * OVS);
   localparam logic [CW:0] TH_5 = (CW + 1)'(5 * OVS);
   localparam logic [CW:0] TH_7 = (CW + 1)'(7 * OVS);

   logic          sync_1, sync_2, sync_3;
   logic          edge_det;
   logic [CW-1:0] cnt;
   logic [CW-1:0] width;
   logic [CW:0]   width_x2;
   pulse_t        cls;

   assign edge_det = sync_2 ^ sync_3;
   assign width    = cnt + CW'(1);
   assign width_x2 = {width, 1'b0};

   always_comb begin
      cls = BAD;
      if (width_x2 < TH_1)      cls = BAD;
      else if (width_x2 < TH_3) cls = T1;
      else if (width_x2 < TH_5) cls = T2;
      else if (width_x2 < TH_7) cls = T3;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_1    <= 1'b0;
         sync_2    <= 1'b0;
         sync_3    <= 1'b0;
         cnt       <= '0;
         pulse_vld <= 1'b0;
         pulse_dat <= T1;
      end else begin
         sync_1    <= rx_i;
         sync_2    <= sync_1;
         sync_3    <= sync_2;
         pulse_vld <= 1'b0;
         if (edge_det) begin
            cnt       <= '0;
            pulse_vld <= 1'b1;
            pulse_dat <= cls;
         end else if (cnt < SAT) begin
            cnt <= cnt + CW'(1);
            if (cnt == SAT_M1) begin
               pulse_vld <= 1'b1;
               pulse_dat <= BAD;
            end
         end
      end
   end

endmodule

// File: rtl/spdif_aes3_receiver.sv
// Decodes biphase-mark subframes into paired {R,L} PCM samples with V/U/C status and lock.
// Latency: sample_valid_o 1 clk after the right subframe's last pulse is classified. No backpressure.
module spdif_aes3_receiver
   import spdif_aes3_receiver_pkg::*;
#(
   parameter int SAMPLE_WIDTH = 16,
   parameter int OVS          = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      rx_i,
   output logic [2*SAMPLE_WIDTH-1:0] sample_o,
   output logic                      sample_valid_o,
   output logic                      block_start_o,
   output logic [5:0]                status_o,
   output logic                      parity_err_o,
   output logic                      locked_o
);

   localparam int AUD_LSB = (SAMPLE_WIDTH == 24) ? 0 : 4;

   assert property (@(posedge clk)
      (SAMPLE_WIDTH == 16 || SAMPLE_WIDTH == 20 || SAMPLE_WIDTH == 24) && OVS >= 4 && (OVS % 2) == 0);

   logic      pulse_vld;
   pulse_t    pulse_dat;

   rx_state_t state;
   logic [3:0] pre_buf;
   logic [1:0] pre_cnt;
   pre_kind_t kind_q;
   logic [4:0] slot;
   logic       half;
   logic [26:0] sr;
   logic [SAMPLE_WIDTH-1:0] left_smp;
   logic [2:0] left_vuc;
   logic       left_ok;
   logic       z_flag;
   logic [1:0] good_cnt;

   logic       bit_done, bit_val, code_err, pre_hit, sub_end;
   pre_kind_t  pre_kind;
   logic [5:0] pre_pat;
   logic [27:0] word;
   subframe_t  side;

   spdif_aes3_pulse_meter #(.OVS(OVS)) u_meter (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx_i      (rx_i),
      .pulse_vld (pulse_vld),
      .pulse_dat (pulse_dat)
   );

   always_comb begin
      bit_done = 1'b0;
      bit_val  = 1'b0;
      code_err = 1'b0;
      pre_hit  = 1'b0;
      pre_kind = PRE_X;
      pre_pat  = {pre_buf, pulse_dat};
      if (pulse_vld) begin
         case (state)
            PRE: begin
               if (pulse_dat == BAD) code_err = 1'b1;
               else if (pre_cnt == 2'd2) begin
                  if (pre_pat == PAT_X) begin
                     pre_hit = 1'b1;
                     pre_kind = PRE_X;
                  end else if (pre_pat == PAT_Y) begin
                     pre_hit = 1'b1;
                     pre_kind = PRE_Y;
                  end else if (pre_pat == PAT_Z) begin
                     pre_hit = 1'b1;
                     pre_kind = PRE_Z;
                  end else code_err = 1'b1;
               end
            end
            DATA: begin
               // A lone T1 opens a '1' cell; only a second T1 may close it.
               if (half) begin
                  if (pulse_dat == T1) begin
                     bit_done = 1'b1;
                     bit_val  = 1'b1;
                  end else code_err = 1'b1;
               end else if (pulse_dat == T2) bit_done = 1'b1;
               else if (pulse_dat != T1) code_err = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign word    = {bit_val, sr};
   assign sub_end = bit_done && (slot == SLOT_LAST);
   assign side    = (kind_q == PRE_Y) ? RIGHT : LEFT;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= HUNT;
         pre_buf        <= '0;
         pre_cnt        <= '0;
         kind_q         <= PRE_X;
         slot           <= '0;
         half           <= 1'b0;
         sr             <= '0;
         left_smp       <= '0;
         left_vuc       <= '0;
         left_ok        <= 1'b0;
         z_flag         <= 1'b0;
         good_cnt       <= '0;
         sample_o       <= '0;
         sample_valid_o <= 1'b0;
         block_start_o  <= 1'b0;
         status_o       <= '0;
         parity_err_o   <= 1'b0;
         locked_o       <= 1'b0;
      end else begin
         sample_valid_o <= 1'b0;
         parity_err_o   <= 1'b0;
         if (pulse_vld) begin
            case (state)
               HUNT: if (pulse_dat == T3) begin
                  state   <= PRE;
                  pre_cnt <= '0;
               end
               PRE: if (pre_hit) begin
                  state  <= DATA;
                  kind_q <= pre_kind;
                  slot   <= SLOT_FIRST;
                  half   <= 1'b0;
               end else if (!code_err) begin
                  pre_buf <= {pre_buf[1:0], pulse_dat};
                  pre_cnt <= pre_cnt + 2'd1;
               end
               DATA: if (bit_done) begin
                  half <= 1'b0;
                  sr   <= {bit_val, sr[26:1]};
                  slot <= slot + 5'd1;
               end else if (!code_err) half <= 1'b1;
               default: state <= HUNT;
            endcase
         end

         if (code_err) begin
            state    <= HUNT;
            locked_o <= 1'b0;
            good_cnt <= '0;
            left_ok  <= 1'b0;
         end

         if (sub_end) begin
            state <= HUNT;
            if (^word) begin
               parity_err_o <= 1'b1;
               left_ok      <= 1'b0;
               locked_o     <= 1'b0;
               good_cnt     <= '0;
            end else begin
               if (good_cnt != 2'd2) good_cnt <= good_cnt + 2'd1;
               locked_o <= (good_cnt != 2'd0);
               if (side == LEFT) begin
                  left_smp <= word[AUD_LSB +: SAMPLE_WIDTH];
                  left_vuc <= {word[24], word[25], word[26]};
                  left_ok  <= 1'b1;
                  z_flag   <= (kind_q == PRE_Z);
               end else if (left_ok) begin
                  sample_o       <= {word[AUD_LSB +: SAMPLE_WIDTH], left_smp};
                  status_o       <= {word[24], word[25], word[26], left_vuc};
                  block_start_o  <= z_flag;
                  sample_valid_o <= 1'b1;
                  left_ok        <= 1'b0;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_spdif_aes3_receiver.sv
// Drives biphase-mark subframes at OVS=4 into the receiver and checks decoded frames.
module tb_spdif_aes3_receiver;
   import spdif_aes3_receiver_pkg::*;

   localparam int SW  = 16;
   localparam int OVS = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          rx_i = 1'b0;
   logic [2*SW-1:0] sample_o;
   logic          sample_valid_o;
   logic          block_start_o;
   logic [5:0]    status_o;
   logic          parity_err_o;
   logic          locked_o;

   always #5 clk = ~clk;

   spdif_aes3_receiver #(.SAMPLE_WIDTH(SW), .OVS(OVS)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .rx_i           (rx_i),
      .sample_o       (sample_o),
      .sample_valid_o (sample_valid_o),
      .block_start_o  (block_start_o),
      .status_o       (status_o),
      .parity_err_o   (parity_err_o),
      .locked_o       (locked_o)
   );

   int n_vec  = 0;
   int n_miss = 0;
   int n_valid = 0;
   int n_perr  = 0;
   bit jitter  = 1'b0;

   always @(negedge clk) begin
      if (sample_valid_o === 1'b1) n_valid++;
      if (parity_err_o === 1'b1) n_perr++;
   end

   typedef struct {
      pre_kind_t   lk;
      logic [15:0] l;
      logic [15:0] r;
      logic [2:0]  vl;
      logic [2:0]  vr;
      logic [31:0] exp_s;
      logic [5:0]  exp_st;
      logic        exp_bs;
   } vec_t;

   vec_t tbl[4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic pulse(input int cells);
      int n;
      n = cells * OVS;
      if (jitter) n = n + int'($urandom_range(2, 0)) - 1;
      rx_i = ~rx_i;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_sub(input pre_kind_t k, input logic [15:0] smp, input logic [2:0] vuc,
                           input bit corrupt, input int stretch);
      logic [27:0] w;
      w = '0;
      w[19:4] = smp;
      w[24] = vuc[2];
      w[25] = vuc[1];
      w[26] = vuc[0];
      w[27] = ^w[26:0];
      if (corrupt) w[10] = ~w[10];
      pulse(3);
      case (k)
         PRE_X:   begin pulse(3); pulse(1); pulse(1); end
         PRE_Y:   begin pulse(2); pulse(1); pulse(2); end
         default: begin pulse(1); pulse(1); pulse(3); end
      endcase
      for (int i = 0; i < 28; i++) begin
         if (i + 4 == stretch) pulse(4);
         else if (w[i]) begin pulse(1); pulse(1); end
         else pulse(2);
      end
   endtask

   // Closes the last pulse, idles, and reports how many clk until sample_valid_o.
   task automatic end_burst(output int lat);
      lat = -1;
      rx_i = ~rx_i;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         if (sample_valid_o && lat < 0) lat = k;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (24) @(posedge clk);
      #1;
   endtask

   initial begin
      int lat;
      int v0;
      int p0;

      tbl[0] = '{PRE_Z, 16'h1234, 16'hABCD, 3'b001, 3'b001, 32'hABCD_1234, 6'b001_001, 1'b1};
      tbl[1] = '{PRE_X, 16'h0000, 16'hFFFF, 3'b000, 3'b000, 32'hFFFF_0000, 6'b000_000, 1'b0};
      tbl[2] = '{PRE_X, 16'hA5A5, 16'h5A5A, 3'b100, 3'b010, 32'h5A5A_A5A5, 6'b010_100, 1'b0};
      tbl[3] = '{PRE_Z, 16'hFFFF, 16'h0001, 3'b010, 3'b100, 32'h0001_FFFF, 6'b100_010, 1'b1};

      do_reset();
      check("rst_sample", 32'(sample_o), 32'h0);
      check("rst_valid", 32'(sample_valid_o), 32'h0);
      check("rst_status", 32'(status_o), 32'h0);
      check("rst_block", 32'(block_start_o), 32'h0);
      check("rst_perr", 32'(parity_err_o), 32'h0);
      check("rst_locked", 32'(locked_o), 32'h0);

      for (int i = 0; i < 4; i++) begin
         v0 = n_valid;
         send_sub(tbl[i].lk, tbl[i].l, tbl[i].vl, 1'b0, 0);
         send_sub(PRE_Y, tbl[i].r, tbl[i].vr, 1'b0, 0);
         end_burst(lat);
         check($sformatf("tbl%0d_latency", i), 32'(lat), 32'd4);
         check($sformatf("tbl%0d_count", i), 32'(n_valid - v0), 32'd1);
         check($sformatf("tbl%0d_sample", i), sample_o, tbl[i].exp_s);
         check($sformatf("tbl%0d_status", i), 32'(status_o), 32'(tbl[i].exp_st));
         check($sformatf("tbl%0d_block", i), 32'(block_start_o), 32'(tbl[i].exp_bs));
      end

      // Three X,Y frames from reset; lock comes with the second clean subframe.
      do_reset();
      v0 = n_valid;
      send_sub(PRE_X, 16'h1111, 3'b000, 1'b0, 0);
      send_sub(PRE_Y, 16'h2222, 3'b000, 1'b0, 0);
      check("s2_locked_after_1", 32'(locked_o), 32'd0);
      send_sub(PRE_X, 16'h3333, 3'b000, 1'b0, 0);
      check("s2_locked_after_2", 32'(locked_o), 32'd1);
      send_sub(PRE_Y, 16'h4444, 3'b000, 1'b0, 0);
      send_sub(PRE_X, 16'h5555, 3'b000, 1'b0, 0);
      send_sub(PRE_Y, 16'h6666, 3'b000, 1'b0, 0);
      end_burst(lat);
      check("s2_count", 32'(n_valid - v0), 32'd3);
      check("s2_sample", sample_o, 32'h6666_5555);
      check("s2_block", 32'(block_start_o), 32'd0);

      // Parity failure on the left subframe suppresses that frame.
      v0 = n_valid;
      p0 = n_perr;
      send_sub(PRE_Z, 16'h0F0F, 3'b001, 1'b1, 0);
      send_sub(PRE_Y, 16'hF0F0, 3'b001, 1'b0, 0);
      end_burst(lat);
      check("s3_perr", 32'(n_perr - p0), 32'd1);
      check("s3_count", 32'(n_valid - v0), 32'd0);
      check("s3_locked", 32'(locked_o), 32'd0);
      check("s3_sample_held", sample_o, 32'h6666_5555);

      // Stretched pulse mid-DATA: lock drops, decoding resumes at the next preamble.
      v0 = n_valid;
      send_sub(PRE_X, 16'h1357, 3'b000, 1'b0, 0);
      send_sub(PRE_Y, 16'h2468, 3'b000, 1'b0, 0);
      send_sub(PRE_X, 16'hDEAD, 3'b000, 1'b0, 10);
      check("s4_locked_drop", 32'(locked_o), 32'd0);
      send_sub(PRE_X, 16'hC0DE, 3'b000, 1'b0, 0);
      send_sub(PRE_Y, 16'hBEEF, 3'b000, 1'b0, 0);
      end_burst(lat);
      check("s4_count", 32'(n_valid - v0), 32'd2);
      check("s4_sample", sample_o, 32'hBEEF_C0DE);
      check("s4_locked_again", 32'(locked_o), 32'd1);

      // Reset after a held left, then a stream that opens with Y.
      send_sub(PRE_X, 16'h7777, 3'b000, 1'b0, 0);
      rx_i = ~rx_i;
      repeat (10) @(posedge clk);
      #1;
      do_reset();
      check("s5_rst_sample", sample_o, 32'h0);
      check("s5_rst_locked", 32'(locked_o), 32'd0);
      v0 = n_valid;
      send_sub(PRE_Y, 16'h8888, 3'b000, 1'b0, 0);
      send_sub(PRE_X, 16'h9999, 3'b000, 1'b0, 0);
      send_sub(PRE_Y, 16'hAAAA, 3'b000, 1'b0, 0);
      end_burst(lat);
      check("s5_count", 32'(n_valid - v0), 32'd1);
      check("s5_sample", sample_o, 32'hAAAA_9999);

      // Jittered widths on an inverted line.
      jitter = 1'b1;
      rx_i = ~rx_i;
      repeat (24) @(posedge clk);
      #1;
      v0 = n_valid;
      send_sub(PRE_Z, 16'h1234, 3'b001, 1'b0, 0);
      send_sub(PRE_Y, 16'hABCD, 3'b001, 1'b0, 0);
      jitter = 1'b0;
      end_burst(lat);
      check("s6_count", 32'(n_valid - v0), 32'd1);
      check("s6_sample", sample_o, 32'hABCD_1234);
      check("s6_status", 32'(status_o), 32'b001_001);
      check("s6_block", 32'(block_start_o), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
